// File: rtl/header_rr_arbiter.sv
// Round-robin header arbiter: serialises per-port routing requests onto one
// shared routing/allocation engine, with a watchdog that aborts a grant the
// engine never completes.

`ifndef NPORT
`define NPORT 5
`endif

module header_rr_arbiter #(
    parameter int unsigned NPORT    = `NPORT,
    parameter int unsigned SELW     = 3,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NPORT-1:0] i_h,
    input  logic             i_done,
    output logic [NPORT-1:0] o_grant,
    output logic [SELW-1:0]  o_sel,
    output logic             o_sel_valid,
    output logic [NPORT-1:0] o_ack_h,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ACK
    } state_t;

    state_t           state_q,     state_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;
    logic [SELW-1:0]  sel_q,       sel_d;
    logic [7:0]       wcnt_q,      wcnt_d;
    logic [NPORT-1:0] grant_q,     grant_d;
    logic             sel_valid_q, sel_valid_d;
    logic [NPORT-1:0] ack_q,       ack_d;
    logic             timeout_q,   timeout_d;

    // Scratch for the circular priority search
    logic [SELW-1:0]  cand;
    logic [SELW-1:0]  pick;
    logic             found;

    function automatic logic [NPORT-1:0] onehot(input logic [SELW-1:0] idx);
        logic [NPORT-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Next-state and next-output computation for the IDLE/GRANT/ACK machine
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        wcnt_d      = wcnt_q;
        grant_d     = '0;
        sel_valid_d = 1'b0;
        ack_d       = '0;
        timeout_d   = 1'b0;

        // First requester strictly after ptr, wrapping NPORT-1 -> 0;
        // ptr itself is visited last, so the last-served port has lowest priority.
        cand  = ptr_q;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            cand = (cand == SELW'(NPORT - 1)) ? '0 : cand + 1'b1;
            if (!found && i_h[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_d       = pick;
                    wcnt_d      = '0;
                    grant_d     = onehot(pick);
                    sel_valid_d = 1'b1;
                    state_d     = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (i_done) begin
                    ptr_d   = sel_q;
                    ack_d   = onehot(sel_q);
                    state_d = ST_ACK;
                end else if (!i_h[sel_q]) begin
                    ptr_d   = sel_q;
                    state_d = ST_IDLE;
                end else if (wcnt_q == 8'(MAX_WAIT - 1)) begin
                    ptr_d     = sel_q;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wcnt_d      = wcnt_q + 8'd1;
                    grant_d     = onehot(sel_q);
                    sel_valid_d = 1'b1;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous active-high reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= SELW'(NPORT - 1);
            sel_q       <= '0;
            wcnt_q      <= '0;
            grant_q     <= '0;
            sel_valid_q <= 1'b0;
            ack_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            wcnt_q      <= wcnt_d;
            grant_q     <= grant_d;
            sel_valid_q <= sel_valid_d;
            ack_q       <= ack_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_sel       = sel_q;
    assign o_sel_valid = sel_valid_q;
    assign o_ack_h     = ack_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_header_rr_arbiter.sv
// Self-checking bench for header_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.

module tb_header_rr_arbiter;

    localparam int NP = 5;
    localparam int SW = 3;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] h;
    logic          done;
    logic [NP-1:0] o_grant;
    logic [SW-1:0] o_sel;
    logic          o_sel_valid;
    logic [NP-1:0] o_ack_h;
    logic          o_timeout;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the engine, who was served last, how long the
    // owner has waited, which port is being acknowledged this cycle.
    int m_owner;
    int m_last;
    int m_sel;
    int m_age;
    int m_ack;
    int m_to;

    header_rr_arbiter #(
        .NPORT    (NP),
        .SELW     (SW),
        .MAX_WAIT (MW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_h         (h),
        .i_done      (done),
        .o_grant     (o_grant),
        .o_sel       (o_sel),
        .o_sel_valid (o_sel_valid),
        .o_ack_h     (o_ack_h),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit req(input int p);
        return ((h >> p) & NP'(1)) != '0;
    endfunction

    // One clock edge of the reference behaviour, using the inputs just sampled
    task automatic model_step();
        int prev_ack;
        if (rst) begin
            m_owner = -1;
            m_last  = NP - 1;
            m_sel   = 0;
            m_age   = 0;
            m_ack   = -1;
            m_to    = 0;
        end else begin
            prev_ack = m_ack;
            m_ack    = -1;
            m_to     = 0;
            if (m_owner >= 0) begin
                if (done) begin
                    m_ack   = m_owner;
                    m_last  = m_owner;
                    m_owner = -1;
                end else if (!req(m_owner)) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end else if (m_age == MW - 1) begin
                    m_to    = 1;
                    m_last  = m_owner;
                    m_owner = -1;
                end else begin
                    m_age++;
                end
            end else if (prev_ack < 0) begin
                for (int k = 1; k <= NP; k++) begin
                    int p;
                    p = (m_last + k) % NP;
                    if (m_owner < 0 && req(p)) begin
                        m_owner = p;
                        m_sel   = p;
                        m_age   = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("grant", 32'(o_grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("sel_valid", 32'(o_sel_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        check("sel", 32'(o_sel), 32'(m_sel));
        check("ack", 32'(o_ack_h), (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
        check("timeout", 32'(o_timeout), 32'(m_to));
    endtask

    // Advance one cycle: model follows the edge, outputs checked on the falling
    // edge, then the done pulse ends and an acknowledged buffer drops its request.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        done = 1'b0;
        if (m_ack >= 0) h = h & ~(NP'(1) << m_ack);
    endtask

    initial begin
        rst  = 1'b1;
        h    = '0;
        done = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_valid", 32'(o_sel_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Single request, done three cycles after the grant
        h = 5'b00100;
        tick();
        check("t1_sel", 32'(o_sel), 32'd2);
        check("t1_valid", 32'(o_sel_valid), 32'd1);
        tick();
        tick();
        done = 1'b1;
        tick();
        check("t1_ack", 32'(o_ack_h), 32'b00100);
        check("t1_grant_off", 32'(o_grant), 32'd0);
        tick();
        check("t1_ack_once", 32'(o_ack_h), 32'd0);

        // Last-served is port 2, so with all requesting port 3 wins
        h = 5'b11111;
        tick();
        check("t1_ptr", 32'(o_sel), 32'd3);

        // Reset in the middle of a grant
        rst = 1'b1;
        tick();
        check("rst_mid_grant", 32'(o_grant), 32'd0);
        check("rst_mid_valid", 32'(o_sel_valid), 32'd0);
        check("rst_mid_ack", 32'(o_ack_h), 32'd0);
        check("rst_mid_to", 32'(o_timeout), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_first", 32'(o_sel), 32'd0);

        // Rotation with all ports requesting
        for (int p = 0; p < NP; p++) begin
            check("rot_sel", 32'(o_sel), 32'(p));
            check("rot_valid", 32'(o_sel_valid), 32'd1);
            done = 1'b1;
            tick();
            check("rot_ack", 32'(o_ack_h), 32'd1 << p);
            tick();
            if (p < NP - 1) tick();
        end

        // Wrap-around: port 0 before port 4 after serving port 4
        h = 5'b10001;
        tick();
        check("wrap_first", 32'(o_sel), 32'd0);
        done = 1'b1;
        tick();
        tick();
        tick();
        check("wrap_second", 32'(o_sel), 32'd4);
        done = 1'b1;
        tick();
        tick();

        // Watchdog: no done for MAX_WAIT grant cycles
        h = 5'b00010;
        tick();
        check("wd_sel", 32'(o_sel), 32'd1);
        h = 5'b00011;
        for (int c = 1; c < MW; c++) begin
            tick();
            check("wd_hold", 32'(o_timeout), 32'd0);
        end
        tick();
        check("wd_timeout", 32'(o_timeout), 32'd1);
        check("wd_no_ack", 32'(o_ack_h), 32'd0);
        check("wd_drop", 32'(o_grant), 32'd0);
        tick();
        check("wd_next", 32'(o_sel), 32'd0);
        check("wd_to_once", 32'(o_timeout), 32'd0);
        done = 1'b1;
        tick();
        h = '0;
        tick();
        tick();

        // Done coincides with watchdog expiry
        h = 5'b00100;
        tick();
        for (int c = 1; c < MW; c++) tick();
        done = 1'b1;
        tick();
        check("sim_wd_ack", 32'(o_ack_h), 32'b00100);
        check("sim_wd_to", 32'(o_timeout), 32'd0);
        tick();

        // Done coincides with request withdrawal
        h = 5'b01000;
        tick();
        h    = '0;
        done = 1'b1;
        tick();
        check("sim_wd_ack2", 32'(o_ack_h), 32'b01000);
        check("sim_wd_to2", 32'(o_timeout), 32'd0);
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req(p) && ($urandom % 4) == 0) h = h | (NP'(1) << p);
                else if (req(p) && ($urandom % 40) == 0) h = h & ~(NP'(1) << p);
            end
            if (m_owner >= 0) done = (($urandom % 4) == 0);
            else              done = (($urandom % 8) == 0);
            rst = (($urandom % 400) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
